// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Request/response bundle for one requester of mem_arbiter.
//                The requester (CPU datapath or boot loader) holds req with
//                its access fields until it sees a one-cycle ack; rdata is
//                valid with ack for reads and held until the next ack.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int AW = 32
) ();

  logic          req;     // access request, held until ack
  logic          we;      // write enable
  logic [3:0]    wmask;   // byte write mask
  logic [AW-1:0] addr;    // byte address
  logic [31:0]   wdata;   // write data
  logic          ack;     // one-cycle completion pulse
  logic [31:0]   rdata;   // read data, valid with ack on reads

  // Requester side: drives the access, observes completion.
  modport master (
    output req, we, wmask, addr, wdata,
    input  ack, rdata
  );

  // Arbiter side: observes the access, drives completion.
  modport slave (
    input  req, we, wmask, addr, wdata,
    output ack, rdata
  );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port synchronous RAM between the CPU
//                datapath (port C) and the boot loader / debug port (port L).
//                Each access takes IDLE -> ACCESS -> RESP; a waiting port on
//                the other side is granted straight out of RESP so contended
//                traffic streams at one access every two cycles. After reset
//                the block may sit in a boot phase where only the loader is
//                served and the CPU is held; l_done ends that phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW      = 32,    // byte address width, passed through to memory
  parameter bit BOOT_EN = 1'b1   // 1: start in boot phase after reset
) (
  input  wire logic          clk,
  input  wire logic          reset,       // asynchronous, active-high

  mem_arbiter_if.slave       c_bus,       // CPU datapath port
  mem_arbiter_if.slave       l_bus,       // boot loader / debug port

  input  wire logic          i_l_done,    // loader pulse: image loaded
  output logic               o_cpu_run,   // high: CPU FSM may advance

  output logic               o_mem_en,
  output logic               o_mem_we,
  output logic [3:0]         o_mem_wmask,
  output logic [AW-1:0]      o_mem_addr,
  output logic [31:0]        o_mem_wdata,
  input  wire logic [31:0]   i_mem_rdata  // valid the cycle after o_mem_en
);

  // --------------------------------------------------------------------------
  // State encoding and port identifiers
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,   // waiting for an eligible request
    ST_ACCESS = 2'd1,   // memory strobe cycle
    ST_RESP   = 2'd2    // memory data returns, owner acked
  } state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_L = 1'b1;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t        r_state;
  logic          r_owner;     // port whose access is in flight
  logic          r_prio;      // port that wins a tie
  logic          r_boot;      // boot phase: only the loader is eligible

  logic          r_we;        // latched access of the current owner
  logic [3:0]    r_wmask;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;

  logic [31:0]   r_c_rdata;   // last read data returned to each port
  logic [31:0]   r_l_rdata;

  logic          r_c_ack;
  logic          r_l_ack;
  logic          r_mem_en;
  logic          r_mem_we;

  // --------------------------------------------------------------------------
  // Arbitration wires
  // --------------------------------------------------------------------------
  logic          w_c_elig;    // CPU request that may be served now
  logic          w_l_elig;    // loader request that may be served now
  logic          w_idle_win;  // winner when arbitrating from IDLE
  logic          w_resp_req;  // non-owner is asking while in RESP
  logic          w_grant;     // a new access starts this edge
  logic          w_winner;    // port receiving that grant
  logic          w_sel_we;    // winner's access fields
  logic [3:0]    w_sel_wmask;
  logic [AW-1:0] w_sel_addr;
  logic [31:0]   w_sel_wdata;

  // Pick the next port to serve and mux its access fields.
  always_comb begin
    w_c_elig    = c_bus.req & ~r_boot;
    w_l_elig    = l_bus.req;

    // From IDLE: a lone request wins, a tie goes to the priority pointer.
    if (w_c_elig && w_l_elig) begin
      w_idle_win = r_prio;
    end else if (w_l_elig) begin
      w_idle_win = PORT_L;
    end else begin
      w_idle_win = PORT_C;
    end

    // From RESP only the other port can be granted; the owner's req is
    // still high because it has not yet seen its ack, so it is ignored.
    w_resp_req  = (r_owner == PORT_C) ? w_l_elig : w_c_elig;

    w_grant     = ((r_state == ST_IDLE) && (w_c_elig || w_l_elig)) ||
                  ((r_state == ST_RESP) && w_resp_req);
    w_winner    = (r_state == ST_RESP) ? ~r_owner : w_idle_win;

    if (w_winner == PORT_L) begin
      w_sel_we    = l_bus.we;
      w_sel_wmask = l_bus.wmask;
      w_sel_addr  = l_bus.addr;
      w_sel_wdata = l_bus.wdata;
    end else begin
      w_sel_we    = c_bus.we;
      w_sel_wmask = c_bus.wmask;
      w_sel_addr  = c_bus.addr;
      w_sel_wdata = c_bus.wdata;
    end
  end

  // Access sequencer, boot flag and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= PORT_C;
      r_prio    <= PORT_C;
      r_boot    <= BOOT_EN;
      r_we      <= 1'b0;
      r_wmask   <= 4'h0;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_c_rdata <= 32'h0;
      r_l_rdata <= 32'h0;
      r_c_ack   <= 1'b0;
      r_l_ack   <= 1'b0;
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      r_c_ack  <= 1'b0;
      r_l_ack  <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;

      // l_done only matters while booting; an access in flight is unaffected.
      if (r_boot && i_l_done) begin
        r_boot <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_state <= w_grant ? ST_ACCESS : ST_IDLE;
        end

        ST_ACCESS: begin
          r_state <= ST_RESP;
          if (r_owner == PORT_L) begin
            r_l_ack <= 1'b1;
          end else begin
            r_c_ack <= 1'b1;
          end
        end

        ST_RESP: begin
          // Memory data is valid now; keep it for the owner on reads only.
          if (!r_we) begin
            if (r_owner == PORT_L) begin
              r_l_rdata <= i_mem_rdata;
            end else begin
              r_c_rdata <= i_mem_rdata;
            end
          end
          r_state <= w_grant ? ST_ACCESS : ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // A grant latches the winner's access and flips the tie-break.
      if (w_grant) begin
        r_owner  <= w_winner;
        r_prio   <= ~w_winner;
        r_we     <= w_sel_we;
        r_wmask  <= w_sel_wmask;
        r_addr   <= w_sel_addr;
        r_wdata  <= w_sel_wdata;
        r_mem_en <= 1'b1;
        r_mem_we <= w_sel_we;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // During the ack cycle of a read the RAM output is forwarded directly so
  // rdata is valid together with ack; otherwise the captured copy is shown.
  assign c_bus.ack   = r_c_ack;
  assign c_bus.rdata = (r_c_ack && !r_we) ? i_mem_rdata : r_c_rdata;
  assign l_bus.ack   = r_l_ack;
  assign l_bus.rdata = (r_l_ack && !r_we) ? i_mem_rdata : r_l_rdata;

  assign o_cpu_run   = ~r_boot;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_wmask = r_wmask;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

endmodule : mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the core's single unified instruction/data memory between the multicycle CPU datapath (port C) and the boot loader/debug port (port L). It sequences each access to the single-port synchronous RAM and returns read data with a valid strobe. It enforces a boot phase in which only the loader may access memory while the CPU is held idle, then arbitrates round-robin between the two ports.

## Interface
- AW, 32, address width in bits (byte address, passed to memory unchanged)
- BOOT_EN, 1, 1: start in boot phase after reset; 0: CPU runs immediately
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- c_req  in  1  CPU access request; held until c_ack
- c_we  in  1  CPU write enable
- c_wmask  in  4  CPU byte write mask
- c_addr  in  AW  CPU address
- c_wdata  in  32  CPU write data
- c_ack  out  1  one-cycle pulse: CPU access complete
- c_rdata  out  32  CPU read data, valid when c_ack and the access was a read
- l_req, l_we, l_wmask, l_addr, l_wdata  in  1/1/4/AW/32  loader port, same meaning as CPU port
- l_ack  out  1  one-cycle pulse: loader access complete
- l_rdata  out  32  loader read data, valid with l_ack
- l_done  in  1  one-cycle pulse from loader: image loaded, end boot phase
- cpu_run  out  1  high: CPU FSM may advance; low: CPU held at fetch
- mem_en  out  1  memory strobe
- mem_we  out  1  memory write
- mem_wmask  out  4  byte mask
- mem_addr  out  AW  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en

## Operation
- States: IDLE, ACCESS, RESP. Register `owner` (C/L) and priority pointer `prio` (C/L).
- Eligible requesters: boot=1 -> L only; boot=0 -> C and L.
- Arbitration: one eligible request -> it wins; both -> `prio` wins. After a grant, `prio` points to the other port.
- Grant (IDLE->ACCESS, or RESP->ACCESS): latch winner's we/wmask/addr/wdata into internal registers; `owner` <= winner.
- ACCESS: mem_en=1, mem_we/mem_wmask/mem_addr/mem_wdata from latched registers. Always -> RESP.
- RESP: owner's ack=1; owner's rdata <= mem_rdata (captured into an rdata register, held until the next ack on that port). Next state: if the non-owner port is eligible and requesting -> grant it, ACCESS; else IDLE. The owner's own req is ignored in RESP (still high until it sees ack).
- mem_en=0 and mem_we=0 in IDLE and RESP; mem_wmask/mem_addr/mem_wdata hold latched values.
- Write accesses complete through RESP identically; rdata is not updated on writes.
- Request dropped after grant: access still completes and ack is still issued.
- Boot register: reset value BOOT_EN. l_done while boot=1 -> boot<=0 at the next edge. l_done while boot=0 is ignored. cpu_run = ~boot.
- An access in flight when l_done arrives completes normally. A C request held during boot is served after boot clears.

## Timing
- Reset (async): state=IDLE, prio=C, owner=C, boot=BOOT_EN. All acks, mem_en and mem_we are 0. rdata, latched address, data and mask registers are 0. cpu_run = ~BOOT_EN.
- Reset mid-access aborts the access: no ack is issued, and mem_en drops immediately.
- Latency, uncontended: req sampled at edge N -> ACCESS in cycle N..N+1 (mem_en high) -> ack and rdata in cycle N+1..N+2 -> IDLE. That is 2 cycles from the sampling edge to ack, and 3 cycles per isolated access.
- Contended: the second port enters ACCESS directly from RESP. Two accesses finish in 4 cycles after the first sampling edge.
- Same port back-to-back: the requester drops req in the ack cycle and re-raises it. Re-sampling occurs in IDLE, so a minimum of 3 cycles per access.
- c_ack and l_ack are never high in the same cycle. mem_en is never high for two consecutive cycles.

## Test plan
- Boot: reset with BOOT_EN=1; c_req=1 and l_req write addr 0x0 data 0xDEADBEEF. Result: only l_ack pulses and cpu_run=0. Then l_done pulse; cpu_run=1 one cycle later, and c_req is then served.
- Read latency: boot=0. CPU read of 0x4, memory returns 0x12345678. Result: mem_en high exactly 1 cycle after the sampling edge; c_ack=1 with c_rdata=0x12345678 exactly 2 cycles after.
- Round-robin: both ports request continuously for 4 accesses from reset with prio=C. Grant order must be C, L, C, L. Acks arrive on consecutive pairs with no IDLE between C and L.
- Byte write: l_we=1, l_wmask=0b0100, l_addr=0x10, l_wdata=0x00AB0000. Result: mem_we=1 and mem_wmask=0b0100 for one cycle; l_rdata is unchanged.
- Dropped request: c_req deasserted the cycle after grant. Result: the access still completes, and c_ack pulses once.
- Reset during ACCESS: assert reset while mem_en=1. Result: mem_en=0 immediately, no ack, and state IDLE with boot=BOOT_EN after release.
